// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment value encoder.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package ssd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam int unsigned DP_BIT    = 7;
    localparam int unsigned OVF_LIMIT = 9999;
    localparam int unsigned BCD_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low segment pattern (dp bit left off).
// Ports: bcd - 4-bit BCD digit; seg_c - {dp,g,f,e,d,c,b,a}, non-decimal codes blank.
module bcd_to_seg
    import ssd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_value_encoder.sv
// Binary value to four active-low seven-segment patterns via sequential
// double-dabble, with leading-zero blanking, decimal points and overflow dashes.
// Ports: clk, rst (sync, active-high); load/value/dp_mask request a conversion;
//        busy, done (1-cycle pulse), overflow; digit1 (rightmost) .. digit4.
module ssd_value_encoder
    import ssd_pkg::*;
#(
    parameter int unsigned WIDTH         = 14,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       dp_mask,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [7:0]       digit1,
    output logic [7:0]       digit2,
    output logic [7:0]       digit3,
    output logic [7:0]       digit4
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             dp_q, dp_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic [3:0][7:0]        digit_q, digit_d;

    logic [BCD_W-1:0]       bcd_adj_c;
    logic [3:0][7:0]        seg_c;
    logic [3:0][7:0]        disp_c;
    logic [3:0]             blank_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            dp_q       <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digit_q    <= {4{SEG_BLANK}};
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dp_q       <= dp_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digit_q    <= digit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj_c[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Per-digit segment decode
    for (genvar g = 0; g < 4; g++) begin : g_seg
        bcd_to_seg u_bcd_to_seg (
            .bcd   (bcd_q[g*4 +: 4]),
            .seg_c (seg_c[g])
        );
    end

    // Final display patterns: a digit blanks only if every digit left of it is zero too
    always_comb begin
        blank_c    = '0;
        blank_c[3] = BLANK_LEADING && (bcd_q[15:12] == 4'd0);
        blank_c[2] = blank_c[3] && (bcd_q[11:8] == 4'd0);
        blank_c[1] = blank_c[2] && (bcd_q[7:4] == 4'd0);
        disp_c     = '0;
        for (int i = 0; i < 4; i++) begin
            disp_c[i] = blank_c[i] ? SEG_BLANK : seg_c[i];
            if (dp_q[i]) disp_c[i][DP_BIT] = 1'b0;
            if (ovf_pend_q) disp_c[i] = SEG_DASH;
        end
    end

    // Datapath and output register updates
    always_comb begin
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dp_d       = dp_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        digit_d    = digit_q;
        done_d     = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d      = value;
                    dp_d       = dp_mask;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(value) > OVF_LIMIT);
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
            end
            ST_UPDATE: begin
                digit_d    = disp_c;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign digit1   = digit_q[0];
    assign digit2   = digit_q[1];
    assign digit3   = digit_q[2];
    assign digit4   = digit_q[3];

endmodule
